ocp_master_qbridge: RTL and testbench

OCP_MASTER_QBRIDGE -- requirements
Module: ocp_master_qbridge

---
 rtl/ocp_pkg.sv | 23 ++
 rtl/ocp_if.sv | 18 +
 rtl/ocp_sync_fifo.sv | 51 +++++
 rtl/ocp_master_qbridge.sv | 100 ++++++++++
 tb/tb_ocp_master_qbridge.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ocp_pkg.sv
// rtl/ocp_pkg.sv - OCP command/response encodings shared by the bridge, its FIFO users and the bus interface
package ocp_pkg;
  localparam int CMD_W  = 3;
  localparam int RESP_W = 2;

  typedef enum logic [CMD_W-1:0] {
    OCP_CMD_IDLE = 3'b000,
    OCP_CMD_WR   = 3'b001,
    OCP_CMD_RD   = 3'b010
  } ocp_cmd_e;

  typedef enum logic [RESP_W-1:0] {
    OCP_RESP_NULL = 2'b00,
    OCP_RESP_DVA  = 2'b01,
    OCP_RESP_FAIL = 2'b10,
    OCP_RESP_ERR  = 2'b11
  } ocp_resp_e;

  // FAIL and ERR are the only encodings with the upper bit set
  function automatic logic resp_is_error(input logic [RESP_W-1:0] resp);
    return resp[1];
  endfunction
endpackage

// File: rtl/ocp_if.sv
// rtl/ocp_if.sv - OCP master/slave signal bundle
interface ocp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ocp_pkg::CMD_W-1:0]  m_cmd;
  logic [ADDR_WIDTH-1:0]      m_addr;
  logic [DATA_WIDTH-1:0]      m_data;
  logic                       m_resp_accept;
  logic                       s_cmd_accept;
  logic [ocp_pkg::RESP_W-1:0] s_resp;
  logic [DATA_WIDTH-1:0]      s_data;

  modport master (output m_cmd, m_addr, m_data, m_resp_accept,
                  input  s_cmd_accept, s_resp, s_data);
  modport slave  (input  m_cmd, m_addr, m_data, m_resp_accept,
                  output s_cmd_accept, s_resp, s_data);
endinterface

// File: rtl/ocp_sync_fifo.sv
// rtl/ocp_sync_fifo.sv - single-clock FIFO with clock enable; push when full and pop when empty are dropped
module ocp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = enable && push && !full;
  assign do_pop  = enable && pop && !empty;
  assign head    = mem[rptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_next(wptr);
      if (do_pop)  rptr <= ptr_next(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end
endmodule

// File: rtl/ocp_master_qbridge.sv
// rtl/ocp_master_qbridge.sv - queued request-to-OCP master bridge with outstanding limit, response tagging and timeout
module ocp_master_qbridge
  import ocp_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  ocp_if.master                 m_ocp,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int QW = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [QW-1:0] q_head;
  logic          q_empty, q_full;
  logic [0:0]    tag_head;
  logic          tag_empty, tag_full;
  logic [OW-1:0] outstanding;
  logic [TW-1:0] wait_cnt;
  logic          cmd_busy, cmd_acc, rsp_hs, issue;

  assign cmd_busy = (m_ocp.m_cmd != OCP_CMD_IDLE);
  assign cmd_acc  = enable && cmd_busy && m_ocp.s_cmd_accept;
  assign m_ocp.m_resp_accept = enable && (outstanding != '0);
  assign rsp_hs   = m_ocp.m_resp_accept && !tag_empty && (m_ocp.s_resp != OCP_RESP_NULL);
  // The accept landing this edge already occupies a slot, so it counts toward the limit
  assign issue    = enable && !q_empty && (!cmd_busy || cmd_acc) &&
                    ((int'(outstanding) + int'(cmd_acc)) < MAX_OUTSTANDING);
  assign req_ready = enable && !reset && !q_full;
  assign busy      = !q_empty || cmd_busy || (outstanding != '0);

  ocp_sync_fifo #(.WIDTH(QW), .DEPTH(REQ_DEPTH)) u_req_q (
    .clk(clk), .reset(reset), .enable(enable),
    .push(req_valid && req_ready), .push_data({req_write, req_addr, req_wdata}),
    .pop(issue), .head(q_head), .empty(q_empty), .full(q_full)
  );

  ocp_sync_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk(clk), .reset(reset), .enable(enable),
    .push(cmd_acc && !tag_full), .push_data(m_ocp.m_cmd == OCP_CMD_WR),
    .pop(rsp_hs), .head(tag_head), .empty(tag_empty), .full(tag_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ocp.m_cmd  <= OCP_CMD_IDLE;
      m_ocp.m_addr <= '0;
      m_ocp.m_data <= '0;
    end else if (issue) begin
      m_ocp.m_cmd  <= q_head[QW-1] ? OCP_CMD_WR : OCP_CMD_RD;
      m_ocp.m_addr <= q_head[QW-2 -: ADDR_WIDTH];
      m_ocp.m_data <= q_head[DATA_WIDTH-1:0];
    end else if (cmd_acc) begin
      m_ocp.m_cmd  <= OCP_CMD_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_rdata   <= '0;
    end else if (enable) begin
      outstanding <= outstanding + OW'(cmd_acc) - OW'(rsp_hs);
      if ((outstanding == '0) || rsp_hs) begin
        wait_cnt <= '0;
      end else if (wait_cnt != TW'(TIMEOUT_CYCLES)) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
      end
      rsp_valid <= rsp_hs;
      if (rsp_hs) begin
        rsp_write <= tag_head[0];
        rsp_error <= resp_is_error(m_ocp.s_resp);
        if (!tag_head[0]) rsp_rdata <= m_ocp.s_data;
      end
    end
  end
endmodule

// File: tb/tb_ocp_master_qbridge.sv
// tb/tb_ocp_master_qbridge.sv - randomized and directed self-checking bench for ocp_master_qbridge
module tb_ocp_master_qbridge;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int QD = 4;
  localparam int MO = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_write, rsp_error, busy, timeout_err;
  logic [DW-1:0] rsp_rdata;

  ocp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ocp_master_qbridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REQ_DEPTH(QD),
    .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(rst), .enable(enable), .m_ocp(bus),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: request queue, presented command, in-flight write tags
  typedef struct packed { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } req_t;
  req_t          mq[$];
  bit            mtags[$];
  bit            mc_v;
  req_t          mc;
  bit            mrv, mrw, mre, mterr;
  logic [DW-1:0] mrd;
  int            mwait;

  function automatic void model_reset();
    mq.delete(); mtags.delete();
    mc_v = 0; mc = '0; mrv = 0; mrw = 0; mre = 0; mterr = 0; mrd = '0; mwait = 0;
  endfunction

  function automatic void model_step();
    bit acc, hs, ready, w;
    int n_out;
    if (!enable) return;
    n_out = mtags.size();
    acc   = mc_v && bus.s_cmd_accept;
    hs    = (n_out > 0) && (bus.s_resp != 2'b00);
    ready = mq.size() < QD;
    mrv = hs;
    if (hs) begin
      w = mtags.pop_front();
      mrw = w;
      mre = (bus.s_resp == 2'b10) || (bus.s_resp == 2'b11);
      if (!w) mrd = bus.s_data;
    end
    if (n_out == 0 || hs) mwait = 0;
    else begin
      mwait++;
      if (mwait >= TO) mterr = 1;
    end
    if (acc) mtags.push_back(mc.w);
    if (mq.size() > 0 && (!mc_v || acc) && (n_out + int'(acc)) < MO) begin
      mc = mq.pop_front();
      mc_v = 1;
    end else if (acc) mc_v = 0;
    if (req_valid && ready) mq.push_back('{w: req_write, a: req_addr, d: req_wdata});
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      chk("rst_m_cmd", bus.m_cmd, 0);
      chk("rst_m_addr", bus.m_addr, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_resp_accept", bus.m_resp_accept, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp", {rsp_valid, rsp_write, rsp_error, timeout_err}, 0);
      chk("rst_rdata", rsp_rdata, 0);
    end else begin
      chk("m_cmd", bus.m_cmd, mc_v ? (mc.w ? 3'b001 : 3'b010) : 3'b000);
      if (mc_v) begin
        chk("m_addr", bus.m_addr, mc.a);
        chk("m_data", bus.m_data, mc.d);
      end
      chk("m_resp_accept", bus.m_resp_accept, enable && mtags.size() > 0);
      chk("req_ready", req_ready, enable && mq.size() < QD);
      chk("busy", busy, mq.size() > 0 || mc_v || mtags.size() > 0);
      chk("rsp_valid", rsp_valid, mrv);
      if (mrv) begin
        chk("rsp_write", rsp_write, mrw);
        chk("rsp_error", rsp_error, mre);
      end
      chk("rsp_rdata", rsp_rdata, mrd);
      chk("timeout_err", timeout_err, mterr);
      model_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    enable = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    bus.s_cmd_accept = 1'b0; bus.s_resp = 2'b00; bus.s_data = '0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    idle_inputs();
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    req_valid = 1'b0; enable = 1'b1; bus.s_cmd_accept = 1'b1; bus.s_resp = 2'b01;
    for (i = 0; i < 60 && busy; i++) cyc();
    chk(name, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int pulses, pushes, issued, waits, nrsp;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    idle_inputs();
    enable = 1'b0;

    // Single read answered DVA
    do_reset();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h03;
    bus.s_cmd_accept = 1'b1; bus.s_resp = 2'b01; bus.s_data = 32'hDEADBEEF;
    cyc(); req_valid = 1'b0;
    cyc();
    chk("lat_m_cmd", bus.m_cmd, 3'b010);
    chk("lat_m_addr", bus.m_addr, 5'h03);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin
        pulses++;
        chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_write", rsp_write, 0);
        chk("rd_error", rsp_error, 0);
      end
    end
    chk("rd_pulses", pulses, 1);
    chk("rd_busy_after", busy, 0);

    // Write burst against outstanding limit, responses withheld
    do_reset();
    bus.s_cmd_accept = 1'b1; req_valid = 1'b1; req_write = 1'b1;
    pushes = 0; issued = 0;
    for (int i = 0; i < 10; i++) begin
      req_addr = AW'(i); req_wdata = $urandom;
      @(negedge clk); #1;
      if (req_ready) pushes++;
      if (bus.m_cmd != 3'b000) issued++;
      cyc();
    end
    req_valid = 1'b0;
    chk("burst_pushes", pushes, 6);
    chk("burst_issued", issued, 2);
    chk("burst_m_cmd_idle", bus.m_cmd, 0);
    chk("burst_req_ready", req_ready, 0);
    chk("burst_busy", busy, 1);
    drain("burst_drain");

    // Command held while slave refuses to accept
    do_reset();
    a = AW'($urandom); d = $urandom;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    cyc(); req_valid = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("hold_m_cmd", bus.m_cmd, 3'b001);
      chk("hold_m_addr", bus.m_addr, a);
      chk("hold_m_data", bus.m_data, d);
      cyc();
    end
    drain("hold_drain");

    // ERR response followed by DVA
    do_reset();
    bus.s_cmd_accept = 1'b1; bus.s_resp = 2'b11; bus.s_data = $urandom;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h01;
    cyc(); req_addr = 5'h02;
    cyc(); req_valid = 1'b0;
    nrsp = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (rsp_valid) begin
        chk(nrsp == 0 ? "err_first" : "err_second", rsp_error, nrsp == 0 ? 1 : 0);
        nrsp++;
        bus.s_resp = 2'b01;
      end
    end
    chk("err_pulses", nrsp, 2);

    // Timeout then asynchronous reset
    do_reset();
    bus.s_cmd_accept = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h07;
    cyc(); req_valid = 1'b0;
    waits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (timeout_err) break;
      if (bus.m_resp_accept) waits++;
    end
    chk("to_set", timeout_err, 1);
    chk("to_waits", waits, TO);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("to_sticky", timeout_err, 1);
    end
    cyc(); bus.s_cmd_accept = 1'b0; req_valid = 1'b1;
    cyc(); req_valid = 1'b0;
    cyc(); cyc();
    chk("to_cmd_pending", bus.m_cmd, 3'b010);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_m_cmd", bus.m_cmd, 0);
    chk("arst_timeout", timeout_err, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_resp_accept", bus.m_resp_accept, 0);
    bus.s_resp = 2'b01; bus.s_cmd_accept = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("post_rst_ignored", rsp_valid, 0);
    end

    // Enable dropped mid-burst
    do_reset();
    bus.s_cmd_accept = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = (i < 8); req_write = $urandom % 2;
      req_addr = AW'($urandom); req_wdata = $urandom;
      bus.s_resp = ($urandom % 2) ? 2'b01 : 2'b00; bus.s_data = $urandom;
      enable = !(i >= 4 && i < 9);
      #1;
      if (!enable) begin
        chk("freeze_ready", req_ready, 0);
        chk("freeze_resp_accept", bus.m_resp_accept, 0);
      end
      cyc();
    end
    drain("freeze_drain");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rst = ($urandom % 700) == 0;
      enable = ($urandom % 10) != 0;
      req_valid = $urandom % 2; req_write = $urandom % 2;
      req_addr = AW'($urandom); req_wdata = $urandom;
      bus.s_cmd_accept = ($urandom % 3) != 0;
      case ($urandom % 8)
        4, 5:    bus.s_resp = 2'b01;
        6:       bus.s_resp = 2'b10;
        7:       bus.s_resp = 2'b11;
        default: bus.s_resp = 2'b00;
      endcase
      bus.s_data = $urandom;
    end
    cyc();
    rst = 1'b0;
    drain("final_drain");
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
